// File: rtl/vc_timer.sv
// Memory-mapped 16-bit timer: prescaler, COUNT/COMPARE match with reload, sticky PEND and level IRQ.
// Define VC_TIMER_WDOG_EN to compile in the watchdog (WDLOAD/WDKICK registers, wdog_reset pulse).
module vc_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  io_addr,
   input  logic        io_write,
   input  logic        io_read,
   input  logic [15:0] io_wdata,
   output logic [15:0] io_rdata,
   output logic        interrupt,
   output logic        wdog_reset
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned PSC_W  = 4;

   localparam logic [3:0] A_COUNT   = 4'd0;
   localparam logic [3:0] A_COMPARE = 4'd1;
   localparam logic [3:0] A_CTRL    = 4'd2;
   localparam logic [3:0] A_STATUS  = 4'd3;

   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] compare_q, compare_d;
   logic [DATA_W-1:0] presc_q, presc_d;
   logic [PSC_W-1:0]  psc_q, psc_d;
   logic              en_q, en_d;
   logic              reload_q, reload_d;
   logic              ie_q, ie_d;
   logic              pend_q, pend_d;
   logic              irq_q, irq_d;

   logic [DATA_W-1:0] psc_mask;
   logic [DATA_W-1:0] rdata;
   logic              tick;
   logic              match;
   logic              count_wr, compare_wr, ctrl_wr, status_wr;

   assign count_wr   = io_write && (io_addr == A_COUNT);
   assign compare_wr = io_write && (io_addr == A_COMPARE);
   assign ctrl_wr    = io_write && (io_addr == A_CTRL);
   assign status_wr  = io_write && (io_addr == A_STATUS);

   // Tick when the low PSC bits of the prescaler are all ones (PSC=0 gives an empty mask).
   assign psc_mask = DATA_W'((32'd1 << psc_q) - 32'd1);
   assign tick     = (presc_q & psc_mask) == psc_mask;

   // A COUNT write in the same cycle suppresses both increment and match.
   assign match = tick && en_q && !count_wr && (count_q == compare_q);

   always_comb begin
      presc_d   = presc_q + DATA_W'(1);
      count_d   = count_q;
      compare_d = compare_q;
      psc_d     = psc_q;
      en_d      = en_q;
      reload_d  = reload_q;
      ie_d      = ie_q;
      pend_d    = pend_q;

      if (ctrl_wr) begin
         en_d     = io_wdata[0];
         reload_d = io_wdata[1];
         ie_d     = io_wdata[2];
         psc_d    = io_wdata[7:4];
         if (io_wdata[7:4] != psc_q) begin
            presc_d = '0;
         end
      end

      if (compare_wr) begin
         compare_d = io_wdata;
      end

      if (count_wr) begin
         count_d = io_wdata;
      end else if (tick && en_q) begin
         if (match && reload_q) begin
            count_d = '0;
         end else begin
            count_d = count_q + DATA_W'(1);
         end
      end

      // Clear first so that a coincident match set takes priority.
      if (status_wr && io_wdata[0]) begin
         pend_d = 1'b0;
      end
      if (match) begin
         pend_d = 1'b1;
      end

      irq_d = pend_d & ie_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         compare_q <= '1;
         presc_q   <= '0;
         psc_q     <= '0;
         en_q      <= 1'b0;
         reload_q  <= 1'b0;
         ie_q      <= 1'b0;
         pend_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         presc_q   <= presc_d;
         psc_q     <= psc_d;
         en_q      <= en_d;
         reload_q  <= reload_d;
         ie_q      <= ie_d;
         pend_q    <= pend_d;
         irq_q     <= irq_d;
      end
   end

   assign interrupt = irq_q;

`ifdef VC_TIMER_WDOG_EN
   localparam logic [3:0]        A_WDLOAD = 4'd4;
   localparam logic [3:0]        A_WDKICK = 4'd5;
   localparam logic [DATA_W-1:0] KICK_KEY = 16'h5A5A;

   logic [DATA_W-1:0] wd_load_q, wd_load_d;
   logic [DATA_W-1:0] wd_cnt_q, wd_cnt_d;
   logic              wd_en_q, wd_en_d;
   logic              wdog_q, wdog_d;
   logic              wdload_wr, wdkick_wr;

   assign wdload_wr = io_write && (io_addr == A_WDLOAD);
   assign wdkick_wr = io_write && (io_addr == A_WDKICK);

   // Load beats kick beats tick; expiry reloads the counter and pulses for one cycle.
   always_comb begin
      wd_load_d = wd_load_q;
      wd_cnt_d  = wd_cnt_q;
      wd_en_d   = wd_en_q;
      wdog_d    = 1'b0;
      if (wdload_wr && (io_wdata != '0)) begin
         wd_load_d = io_wdata;
         wd_cnt_d  = io_wdata;
         wd_en_d   = 1'b1;
      end else if (wdkick_wr && (io_wdata == KICK_KEY)) begin
         wd_cnt_d = wd_load_q;
      end else if (wd_en_q && tick) begin
         if (wd_cnt_q == DATA_W'(1)) begin
            wdog_d   = 1'b1;
            wd_cnt_d = wd_load_q;
         end else if (wd_cnt_q != '0) begin
            wd_cnt_d = wd_cnt_q - DATA_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_load_q <= '0;
         wd_cnt_q  <= '0;
         wd_en_q   <= 1'b0;
         wdog_q    <= 1'b0;
      end else begin
         wd_load_q <= wd_load_d;
         wd_cnt_q  <= wd_cnt_d;
         wd_en_q   <= wd_en_d;
         wdog_q    <= wdog_d;
      end
   end

   assign wdog_reset = wdog_q;
`else
   assign wdog_reset = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      case (io_addr)
         A_COUNT:   rdata = count_q;
         A_COMPARE: rdata = compare_q;
         A_CTRL:    rdata = {8'h00, psc_q, 1'b0, ie_q, reload_q, en_q};
         A_STATUS:  rdata = {15'h0000, pend_q};
`ifdef VC_TIMER_WDOG_EN
         A_WDLOAD:  rdata = wd_load_q;
`endif
         default:   rdata = '0;
      endcase
   end

   // Read data is qualified by the read strobe; reading never changes state.
   assign io_rdata = io_read ? rdata : '0;

endmodule

// File: tb/tb_vc_timer.sv
// Directed self-checking bench for vc_timer; watchdog steps compile in with VC_TIMER_WDOG_EN.
module tb_vc_timer;

   logic        clk;
   logic        reset;
   logic [3:0]  io_addr;
   logic        io_write;
   logic        io_read;
   logic [15:0] io_wdata;
   logic [15:0] io_rdata;
   logic        interrupt;
   logic        wdog_reset;

   int n_cmp = 0;
   int n_err = 0;

   vc_timer dut (
      .clk        (clk),
      .reset      (reset),
      .io_addr    (io_addr),
      .io_write   (io_write),
      .io_read    (io_read),
      .io_wdata   (io_wdata),
      .io_rdata   (io_rdata),
      .interrupt  (interrupt),
      .wdog_reset (wdog_reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
      io_addr = a;
      io_read = 1'b1;
      #1;
      chk(tag, io_rdata, exp);
      io_read = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      io_addr  = a;
      io_wdata = d;
      io_write = 1'b1;
      @(posedge clk);
      #1;
      io_write = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      io_addr  = '0;
      io_write = 1'b0;
      io_read  = 1'b0;
      io_wdata = '0;
      cyc(2);
      reset = 1'b0;

      rd_chk("rst_count", 4'd0, 16'h0000);
      rd_chk("rst_compare", 4'd1, 16'hFFFF);
      rd_chk("rst_ctrl", 4'd2, 16'h0000);
      rd_chk("rst_status", 4'd3, 16'h0000);
      chk("rst_irq", 16'(interrupt), 16'h0000);
      chk("rst_wdog", 16'(wdog_reset), 16'h0000);
      rd_chk("unmapped", 4'd6, 16'h0000);

`ifdef VC_TIMER_WDOG_EN
      // PSC=0 after reset: the watchdog ticks every cycle.
      wr(4'd4, 16'd5);
      rd_chk("wd_load_rd", 4'd4, 16'd5);
      chk("wd_pre0", 16'(wdog_reset), 16'h0000);
      cyc(4);
      chk("wd_pre4", 16'(wdog_reset), 16'h0000);
      cyc(1);
      chk("wd_fire", 16'(wdog_reset), 16'h0001);
      cyc(1);
      chk("wd_one_cycle", 16'(wdog_reset), 16'h0000);
      cyc(2);
      wr(4'd5, 16'h5A5A);
      chk("wd_kick0", 16'(wdog_reset), 16'h0000);
      cyc(1);
      chk("wd_kick_delays", 16'(wdog_reset), 16'h0000);
      cyc(3);
      chk("wd_kick_pre", 16'(wdog_reset), 16'h0000);
      cyc(1);
      chk("wd_kick_fire", 16'(wdog_reset), 16'h0001);
      cyc(1);
      chk("wd_kick_low", 16'(wdog_reset), 16'h0000);
      cyc(2);
      wr(4'd5, 16'h1234);
      chk("wd_badkick0", 16'(wdog_reset), 16'h0000);
      cyc(1);
      chk("wd_badkick_fire", 16'(wdog_reset), 16'h0001);
      rd_chk("wd_kick_rd0", 4'd5, 16'h0000);
      wr(4'd4, 16'h0000);
      rd_chk("wd_load_zero_ign", 4'd4, 16'd5);
`else
      wr(4'd4, 16'd5);
      rd_chk("nowd_load_rd", 4'd4, 16'h0000);
      rd_chk("nowd_kick_rd", 4'd5, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         chk("nowd_wdog", 16'(wdog_reset), 16'h0000);
      end
`endif

      // Free-running match with reload, PSC=0.
      wr(4'd1, 16'd3);
      wr(4'd0, 16'd0);
      wr(4'd2, 16'h0007);
      rd_chk("r27_c0", 4'd0, 16'd0);
      cyc(1);
      rd_chk("r27_c1", 4'd0, 16'd1);
      cyc(1);
      rd_chk("r27_c2", 4'd0, 16'd2);
      cyc(1);
      rd_chk("r27_c3", 4'd0, 16'd3);
      rd_chk("r27_nopend", 4'd3, 16'd0);
      chk("r27_noirq", 16'(interrupt), 16'h0000);
      cyc(1);
      rd_chk("r27_reload", 4'd0, 16'd0);
      rd_chk("r27_pend", 4'd3, 16'd1);
      chk("r27_irq", 16'(interrupt), 16'h0001);
      cyc(4);
      rd_chk("r27_period", 4'd0, 16'd0);

      // Clear coincident with a match: set wins; lone clear then drops PEND.
      cyc(3);
      rd_chk("r30_c3", 4'd0, 16'd3);
      wr(4'd3, 16'h0001);
      rd_chk("r30_setwins", 4'd3, 16'd1);
      chk("r30_irq_kept", 16'(interrupt), 16'h0001);
      rd_chk("r30_c0", 4'd0, 16'd0);
      wr(4'd3, 16'h0001);
      rd_chk("r30_cleared", 4'd3, 16'd0);
      chk("r30_irq_low", 16'(interrupt), 16'h0000);

      // COUNT write coincident with a tick.
      wr(4'd0, 16'h1234);
      rd_chk("r29_wr_wins", 4'd0, 16'h1234);
      cyc(1);
      rd_chk("r29_next", 4'd0, 16'h1235);

      // PSC=2, no reload, wrap through 0xFFFF.
      wr(4'd1, 16'h0010);
      wr(4'd2, 16'h0025);
      rd_chk("r28_ctrl", 4'd2, 16'h0025);
      wr(4'd0, 16'hFFFE);
      rd_chk("r28_fffe", 4'd0, 16'hFFFE);
      cyc(2);
      rd_chk("r28_hold", 4'd0, 16'hFFFE);
      cyc(1);
      rd_chk("r28_ffff", 4'd0, 16'hFFFF);
      cyc(3);
      rd_chk("r28_ffff_hold", 4'd0, 16'hFFFF);
      cyc(1);
      rd_chk("r28_wrap", 4'd0, 16'h0000);
      rd_chk("r28_wrap_nopend", 4'd3, 16'd0);
      cyc(64);
      rd_chk("r28_at10", 4'd0, 16'h0010);
      cyc(3);
      rd_chk("r28_at10_nopend", 4'd3, 16'd0);
      cyc(1);
      rd_chk("r28_noreload", 4'd0, 16'h0011);
      rd_chk("r28_pend", 4'd3, 16'd1);
      chk("r28_irq", 16'(interrupt), 16'h0001);

      // Reset mid-count with PEND set; the write in the reset cycle is dropped.
      wr(4'd0, 16'h0042);
      rd_chk("r32_pre_count", 4'd0, 16'h0042);
      io_addr  = 4'd1;
      io_wdata = 16'h1111;
      io_write = 1'b1;
      reset    = 1'b1;
      cyc(1);
      reset    = 1'b0;
      io_write = 1'b0;
      rd_chk("r32_count", 4'd0, 16'h0000);
      rd_chk("r32_compare", 4'd1, 16'hFFFF);
      rd_chk("r32_ctrl", 4'd2, 16'h0000);
      rd_chk("r32_status", 4'd3, 16'h0000);
      chk("r32_irq", 16'(interrupt), 16'h0000);
      rd_chk("r32_wdload", 4'd4, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("r32_wdog_off", 16'(wdog_reset), 16'h0000);
      end
      rd_chk("r32_count_idle", 4'd0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vc_timer.md
VC_TIMER -- requirements
Module: vc_timer

Interface
REQ-001 Parameter: none; register map fixed, 16-bit data.
REQ-002 clk  in  1  core clock, all state rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_addr  in  4  word register select (core addr[4:1]); the core asserts the strobes only when addr[8:5]==3.
REQ-005 io_write  in  1  one-cycle register write strobe.
REQ-006 io_read  in  1  register read strobe; used only for side-effect-free qualification, never alters state.
REQ-007 io_wdata  in  16  write data.
REQ-008 io_rdata  out  16  combinational read data for io_addr; unmapped addresses read 0.
REQ-009 interrupt  out  1  level interrupt to the interrupt controller.
REQ-010 wdog_reset  out  1  one-cycle watchdog expiry pulse.

Function
REQ-011 Registers: 0 COUNT rw; 1 COMPARE rw; 2 CTRL rw (bit0 EN, bit1 RELOAD, bit2 IE, bits7:4 PSC); 3 STATUS (bit0 PEND, write-1-to-clear); 4 WDLOAD; 5 WDKICK (write-only, reads 0).
REQ-012 Prescaler: 16-bit free-running counter, runs whether or not EN is set; tick asserts for one cycle when prescaler[PSC-1:0] is all ones (PSC=0: tick every cycle); the prescaler wraps naturally.
REQ-013 On tick with EN=1: if COUNT==COMPARE then PEND<=1 and COUNT<=0 when RELOAD=1, else COUNT<=COUNT+1; otherwise COUNT<=COUNT+1, wrapping 0xFFFF->0x0000 with no flag.
REQ-014 Match is evaluated on the pre-increment value; the latency from COUNT==COMPARE with tick to PEND visible is 1 cycle.
REQ-015 COUNT write in the same cycle as a tick: the written value wins, no increment, no match evaluated that cycle.
REQ-016 STATUS write-1 clear and a match set in the same cycle: set wins, PEND=1.
REQ-017 A CTRL write changing PSC resets the prescaler to 0 in that cycle; the next tick occurs 2^PSC cycles later.
REQ-018 interrupt = PEND & IE, driven from flops, no combinational path from io inputs.
REQ-019 Reads have no side effects; io_rdata is valid in the same cycle as io_addr.

Reset
REQ-020 On reset: COUNT=0, COMPARE=0xFFFF, CTRL=0, PEND=0, prescaler=0, WDLOAD=0, watchdog disabled, counter=0; interrupt=0, wdog_reset=0, from the first cycle after reset.
REQ-021 Reset asserted mid-count aborts all pending updates; writes in the reset cycle are ignored.

Configuration
REQ-022 Macro VC_TIMER_WDOG_EN compiles in the watchdog (REQ-023..REQ-026).
REQ-023 With the macro: a WDLOAD write of nonzero V stores V, loads the watchdog counter with V and sets the sticky enable (cleared only by reset); writing 0 is ignored.
REQ-024 With the macro: a WDKICK write of exactly 0x5A5A reloads the counter from WDLOAD; any other value is ignored.
REQ-025 With the macro: when enabled, the counter decrements on every prescaler tick, independent of EN; at the tick where the counter is 1 it reaches 0, wdog_reset pulses for one cycle, and the counter reloads from WDLOAD. A kick in the same cycle as a tick wins.
REQ-026 Without the macro: registers 4/5 read 0 and ignore writes; wdog_reset is tied 0; no watchdog flops.

Verification
REQ-027 PSC=0, COMPARE=3, CTRL=0x07, COUNT=0 -> PEND and interrupt rise 1 cycle after COUNT==3; COUNT then 0,1,2,3 repeating (period 4).
REQ-028 PSC=2, RELOAD=0, COUNT=0xFFFE, COMPARE=0x10 -> COUNT steps every 4 cycles to 0xFFFF, then 0x0000; no PEND until COUNT reaches 0x10.
REQ-029 COUNT write 0x1234 coincident with a tick -> COUNT reads 0x1234 the next cycle, not 0x1235.
REQ-030 PEND=1, STATUS write 0x0001 coincident with a new match -> PEND stays 1; a later lone write of 0x0001 -> PEND 0 and interrupt 0.
REQ-031 Macro on, PSC=0, WDLOAD=5, no kick -> wdog_reset high for exactly 1 cycle, 5 ticks after the load; a kick 0x5A5A at tick 3 delays it; kick 0x1234 does not.
REQ-032 Reset asserted with COUNT=0x0042 and PEND=1 -> all registers at reset values the next cycle, interrupt=0.
